lsu_mem_stage: RTL

//  Parametrised pipeline MEM stage with an integrated load/store unit. It replaces the fixed word-only

---
 rtl/lsu_mem_stage_if.sv | 48 ++++
 rtl/lsu_mem_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage_if.sv
// Bundle of the EX/MEM-side and MEM/WB-side handshake and payload signals of
// the load/store MEM stage. The stage itself connects through the slave
// modport; the upstream/downstream side (or a bench) uses the master modport.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both 1. A producer holding valid=1 keeps its
// payload stable until that edge. valid never depends combinationally on
// ready.
interface lsu_mem_stage_if;
    // EX/MEM side
    logic        in_valid;
    logic        in_ready;
    logic        in_memread;
    logic        in_memwrite;
    logic [2:0]  in_funct3;
    logic [31:0] in_aluresult;
    logic [31:0] in_writedata;
    logic [4:0]  in_rd;
    logic [31:0] in_pcplus4;
    logic        in_regwrite;
    logic [1:0]  in_resultsrc;
    // MEM/WB side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_readdata;
    logic [31:0] out_aluresult;
    logic [4:0]  out_rd;
    logic [31:0] out_pcplus4;
    logic [1:0]  out_resultsrc;
    logic        out_regwrite;
    logic        out_misalign;

    modport master (
        output in_valid, in_memread, in_memwrite, in_funct3, in_aluresult,
               in_writedata, in_rd, in_pcplus4, in_regwrite, in_resultsrc,
               out_ready,
        input  in_ready, out_valid, out_readdata, out_aluresult, out_rd,
               out_pcplus4, out_resultsrc, out_regwrite, out_misalign
    );

    modport slave (
        input  in_valid, in_memread, in_memwrite, in_funct3, in_aluresult,
               in_writedata, in_rd, in_pcplus4, in_regwrite, in_resultsrc,
               out_ready,
        output in_ready, out_valid, out_readdata, out_aluresult, out_rd,
               out_pcplus4, out_resultsrc, out_regwrite, out_misalign
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Pipeline MEM stage with integrated load/store unit.
// - Byte/half/word loads and stores, sign/zero extension of B/H loads.
// - Inferred byte-enable memory of 2**ADDR_W words with MEM_LAT (1..4) cycles
//   of read latency; one op outstanding at a time.
// - Optional misalignment trap: define MEM_MISALIGN_CHECK_EN to flag
//   misaligned H/W accesses (no write, no read wait, regwrite suppressed).
//   Without it, low address bits are ignored and accesses are aligned down.
// dbg_state exposes the FSM state (0 = IDLE, 1 = WAIT).
module lsu_mem_stage #(
    parameter int ADDR_W  = 13,
    parameter int MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_stage_if.slave bus,
    output logic           dbg_state
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // FSM state and read-wait counter
    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    // Handshake / control
    logic in_ready;
    logic accept;
    logic start_load;
    logic load_done;
    logic capture_now;

    // Decode of the incoming op
    logic              size_byte;
    logic              size_half;
    logic              misalign_in;
    logic [1:0]        lo;
    logic [ADDR_W-1:0] widx;
    logic              mem_we;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    // Memory and read pipeline
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_pipe_q [MEM_LAT];
    logic [31:0] rd_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // Fields of the load currently waiting for memory
    logic [2:0]  pend_funct3_q, pend_funct3_d;
    logic [1:0]  pend_lo_q, pend_lo_d;
    logic [31:0] pend_alu_q, pend_alu_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [1:0]  pend_rs_q, pend_rs_d;
    logic        pend_rw_q, pend_rw_d;

    // MEM/WB output registers
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_readdata_q, out_readdata_d;
    logic [31:0] out_alu_q, out_alu_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [1:0]  out_rs_q, out_rs_d;
    logic        out_rw_q, out_rw_d;
    logic        out_mis_q, out_mis_d;

    // Decode access size, lane, misalignment and the store byte-enable mask
    always_comb begin
        lo        = bus.in_aluresult[1:0];
        widx      = bus.in_aluresult[ADDR_W+1:2];
        size_byte = (bus.in_funct3[1:0] == 2'b00);
        size_half = (bus.in_funct3[1:0] == 2'b01);
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_in = (bus.in_memread || bus.in_memwrite) &&
                      ((size_half && lo[0]) ||
                       (!size_byte && !size_half && (lo != 2'b00)));
`else
        misalign_in = 1'b0;
`endif
        accept     = bus.in_valid && in_ready;
        start_load = accept && bus.in_memread && !bus.in_memwrite && !misalign_in;
        mem_we     = accept && bus.in_memwrite && !misalign_in;
        if (size_byte) begin
            wr_be   = 4'b0001 << lo;
            wr_data = {4{bus.in_writedata[7:0]}};
        end else if (size_half) begin
            wr_be   = lo[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{bus.in_writedata[15:0]}};
        end else begin
            wr_be   = 4'b1111;
            wr_data = bus.in_writedata;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: a load parks in WAIT until the read pipeline delivers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_load) begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: acceptance and when the output registers capture
    always_comb begin
        in_ready    = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
        load_done   = (state_q == S_WAIT) && (cnt_q == 2'd0);
        capture_now = (accept && !start_load) || load_done;
        dbg_state   = (state_q == S_WAIT);
    end

    // Byte-enable memory write, committed in the accept cycle
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[widx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Read pipeline: stage MEM_LAT-1 holds the word read in the accept cycle
    // exactly when the wait counter reaches zero
    always_ff @(posedge clk) begin
        rd_pipe_q[0] <= mem_q[widx];
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_pipe_q[i] <= rd_pipe_q[i-1];
        end
    end

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        rd_word   = rd_pipe_q[MEM_LAT-1];
        load_byte = rd_word[{pend_lo_q, 3'b000} +: 8];
        load_half = pend_lo_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (pend_funct3_q[1:0])
            2'b00:   load_data = pend_funct3_q[2] ? {24'd0, load_byte}
                                                  : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_data = pend_funct3_q[2] ? {16'd0, load_half}
                                                  : {{16{load_half[15]}}, load_half};
            default: load_data = rd_word;
        endcase
    end

    // Next values of the pending-load and output registers
    always_comb begin
        pend_funct3_d  = pend_funct3_q;
        pend_lo_d      = pend_lo_q;
        pend_alu_d     = pend_alu_q;
        pend_rd_d      = pend_rd_q;
        pend_pc_d      = pend_pc_q;
        pend_rs_d      = pend_rs_q;
        pend_rw_d      = pend_rw_q;
        out_readdata_d = out_readdata_q;
        out_alu_d      = out_alu_q;
        out_rd_d       = out_rd_q;
        out_pc_d       = out_pc_q;
        out_rs_d       = out_rs_q;
        out_rw_d       = out_rw_q;
        out_mis_d      = out_mis_q;

        if (capture_now) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (start_load) begin
            pend_funct3_d = bus.in_funct3;
            pend_lo_d     = lo;
            pend_alu_d    = bus.in_aluresult;
            pend_rd_d     = bus.in_rd;
            pend_pc_d     = bus.in_pcplus4;
            pend_rs_d     = bus.in_resultsrc;
            pend_rw_d     = bus.in_regwrite;
        end

        // Accepts never coincide with load_done: in_ready is low in WAIT
        if (accept && !start_load) begin
            out_readdata_d = 32'd0;
            out_alu_d      = bus.in_aluresult;
            out_rd_d       = bus.in_rd;
            out_pc_d       = bus.in_pcplus4;
            out_rs_d       = bus.in_resultsrc;
            out_rw_d       = bus.in_regwrite && !misalign_in;
            out_mis_d      = misalign_in;
        end else if (load_done) begin
            out_readdata_d = load_data;
            out_alu_d      = pend_alu_q;
            out_rd_d       = pend_rd_q;
            out_pc_d       = pend_pc_q;
            out_rs_d       = pend_rs_q;
            out_rw_d       = pend_rw_q;
            out_mis_d      = 1'b0;
        end
    end

    // Pending-load and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_funct3_q  <= 3'd0;
            pend_lo_q      <= 2'd0;
            pend_alu_q     <= 32'd0;
            pend_rd_q      <= 5'd0;
            pend_pc_q      <= 32'd0;
            pend_rs_q      <= 2'd0;
            pend_rw_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            out_readdata_q <= 32'd0;
            out_alu_q      <= 32'd0;
            out_rd_q       <= 5'd0;
            out_pc_q       <= 32'd0;
            out_rs_q       <= 2'd0;
            out_rw_q       <= 1'b0;
            out_mis_q      <= 1'b0;
        end else begin
            pend_funct3_q  <= pend_funct3_d;
            pend_lo_q      <= pend_lo_d;
            pend_alu_q     <= pend_alu_d;
            pend_rd_q      <= pend_rd_d;
            pend_pc_q      <= pend_pc_d;
            pend_rs_q      <= pend_rs_d;
            pend_rw_q      <= pend_rw_d;
            out_valid_q    <= out_valid_d;
            out_readdata_q <= out_readdata_d;
            out_alu_q      <= out_alu_d;
            out_rd_q       <= out_rd_d;
            out_pc_q       <= out_pc_d;
            out_rs_q       <= out_rs_d;
            out_rw_q       <= out_rw_d;
            out_mis_q      <= out_mis_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_readdata  = out_readdata_q;
    assign bus.out_aluresult = out_alu_q;
    assign bus.out_rd        = out_rd_q;
    assign bus.out_pcplus4   = out_pc_q;
    assign bus.out_resultsrc = out_rs_q;
    assign bus.out_regwrite  = out_rw_q;
`ifdef MEM_MISALIGN_CHECK_EN
    assign bus.out_misalign  = out_mis_q;
`else
    assign bus.out_misalign  = 1'b0;
`endif
endmodule
